// File: rtl/ls_control_fsm_pkg.sv
// ls_control_fsm_pkg: shared ld/sd decode constants, sequencer state encoding and
// the width of the memory-latency down-counter.
package ls_control_fsm_pkg;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [2:0] F3_D     = 3'b011;
   localparam int         CNT_W    = 4;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_MEM, S_WB, S_ST, S_ERR} state_t;
endpackage

// File: rtl/ls_instr_decode.sv
// ls_instr_decode: combinational ld/sd decoder.
//   instr  in  32  raw instruction word
//   is_ld  out 1   word is RV64 ld
//   is_sd  out 1   word is RV64 sd
//   rs1    out 5   base-address register
//   rs2    out 5   store-data register
//   rd     out 5   load destination register
//   imm    out 12  S-immediate for stores, I-immediate otherwise
module ls_instr_decode
   import ls_control_fsm_pkg::*;
(
   input  logic [31:0] instr,
   output logic        is_ld,
   output logic        is_sd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [11:0] imm
);
   assign is_ld = instr[6:0] == OP_LOAD  && instr[14:12] == F3_D;
   assign is_sd = instr[6:0] == OP_STORE && instr[14:12] == F3_D;
   assign rs1   = instr[19:15];
   assign rs2   = instr[24:20];
   assign rd    = instr[11:7];
   assign imm   = is_sd ? {instr[31:25], instr[11:7]} : instr[31:20];
endmodule

// File: rtl/ls_control_fsm.sv
// ls_control_fsm: multi-cycle ld/sd sequencer driving the LOAD_STORE datapath.
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   instr        in   32     instruction word, sampled on accept
//   instr_valid  in   1      fetch presents a valid instr
//   instr_ready  out  1      high only in IDLE
//   ra           out  5      rs2 for stores, x0 for loads
//   rb           out  5      rs1 base register
//   rw           out  5      rd for loads, x0 for stores
//   c            out  IMM_W  offset immediate
//   we_rf        out  1      register-file write pulse
//   we_mem       out  1      data-memory write pulse
//   busy         out  1      high outside IDLE
//   illegal      out  1      pulse when an accepted word is not ld/sd
module ls_control_fsm
   import ls_control_fsm_pkg::*;
#(
   parameter int IMM_W   = 12,
   parameter int MEM_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [4:0]       ra,
   output logic [4:0]       rb,
   output logic [4:0]       rw,
   output logic [IMM_W-1:0] c,
   output logic             we_rf,
   output logic             we_mem,
   output logic             busy,
   output logic             illegal
);
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              is_ld_q;
   logic              dec_ld, dec_sd;
   logic [4:0]        dec_rs1, dec_rs2, dec_rd;
   logic [11:0]       dec_imm;
   logic              accept;

   ls_instr_decode u_dec (
      .instr (instr),
      .is_ld (dec_ld),
      .is_sd (dec_sd),
      .rs1   (dec_rs1),
      .rs2   (dec_rs2),
      .rd    (dec_rd),
      .imm   (dec_imm)
   );

   assign instr_ready = state == S_IDLE;
   assign busy        = !instr_ready;
   assign accept      = instr_valid && instr_ready;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         S_IDLE: state_n = accept ? ((dec_ld || dec_sd) ? S_ADDR : S_ERR) : S_IDLE;
         S_ADDR: begin
            state_n = S_MEM;
            // the counter holds the MEM cycles still to go after the current one
            cnt_n   = is_ld_q ? CNT_W'(MEM_LAT - 1) : '0;
         end
         S_MEM: begin
            state_n = cnt != '0 ? S_MEM : (is_ld_q ? S_WB : S_ST);
            cnt_n   = cnt != '0 ? cnt - 1'b1 : cnt;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // write pulses are registered off the next state so they line up with WB/ST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         is_ld_q <= 1'b0;
         ra      <= '0;
         rb      <= '0;
         rw      <= '0;
         c       <= '0;
         we_rf   <= 1'b0;
         we_mem  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         we_rf   <= state_n == S_WB && rw != '0;
         we_mem  <= state_n == S_ST;
         illegal <= state_n == S_ERR;
         if (accept && (dec_ld || dec_sd)) begin
            is_ld_q <= dec_ld;
            ra      <= dec_sd ? dec_rs2 : 5'd0;
            rb      <= dec_rs1;
            rw      <= dec_ld ? dec_rd : 5'd0;
            c       <= dec_imm[IMM_W-1:0];
         end
      end
   end
endmodule
